router_modport: RTL and testbench
=================================

# router_modport

Destination-side output port of the 1x3 packet router: one per destination channel. Buffers router-core bytes in a 16-entry FIFO and presents them to the destination agent through a `read_enb` / `valid_out` / `data_out` handshake. If the destination leaves data unread for 30 consecutive cycles, the port flushes itself with a soft reset.

## Interface
Parameters:
- `DEPTH`, default 16: FIFO entries; must be a power of two.
- `WIDTH`, default 8: data byte width.
- `TIMEOUT`, default 30: consecutive unread cycles before soft reset.

Ports:
- `clock`  in  1  single clock; all logic on its rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `write_enb`  in  1  router core writes `data_in` this cycle.
- `lfd_state`  in  1  marks the written byte as a packet header.
- `data_in`  in  WIDTH  byte from the router core.
- `read_enb`  in  1  destination requests a byte.
- `data_out`  out  WIDTH  registered byte delivered to the destination.
- `valid_out`  out  1  FIFO non-empty; data is available.
- `full`  out  1  FIFO holds DEPTH entries.
- `empty`  out  1  FIFO holds 0 entries.
- `soft_reset`  out  1  one-cycle pulse; timeout flush occurred.

## Operation
- Storage: DEPTH × (WIDTH+1) bits. Each entry is `{lfd_state, data_in}`. Bit WIDTH is the header flag.
- Pointers: write and read pointers are log2(DEPTH)+1 bits.
  - `empty` when the pointers are equal.
  - `full` when the low bits are equal and the MSBs differ.
  - Both flags are combinational from the pointers.
- Write: occurs when `write_enb && !full`. The entry is stored at `wr_ptr` and `wr_ptr` increments. A write while full is ignored and nothing is overwritten.
- Read: occurs when `read_enb && !empty`. `data_out` loads `mem[rd_ptr][WIDTH-1:0]` and `rd_ptr` increments. A read while empty is ignored and `data_out` holds.
- Packet tracking (internal 6-bit `pkt_cnt`):
  - On reading a header entry: `pkt_cnt` ← `data[7:2] + 1` (payload length plus parity byte).
  - On reading a non-header entry with `pkt_cnt != 0`: `pkt_cnt` decrements.
  - When a non-header read brings `pkt_cnt` to 0, the packet is complete. No further action is required; `pkt_cnt` is for debug.
- Simultaneous read and write:
  - Both are performed in the same cycle.
  - When full, only the read occurs; the write is blocked that cycle.
  - When empty, only the write occurs; the new byte is not forwarded that cycle.
- `valid_out` = `!empty`.
- Timeout (internal 5-bit `idle_cnt`):
  - Increments on each cycle with `valid_out && !read_enb`.
  - Clears to 0 on any cycle with `read_enb` high or `empty` high.
  - When `idle_cnt == TIMEOUT-1` and the condition still holds at the edge, the port flushes on that edge:
    - both pointers ← 0;
    - `data_out` ← 0;
    - `pkt_cnt` ← 0;
    - `idle_cnt` ← 0;
    - `soft_reset` ← 1 for exactly one cycle.
  - A `write_enb` on the flush edge is discarded.

## Timing
- Reset values while `resetn` = 0:
  - `data_out` = 0, `soft_reset` = 0;
  - pointers, `pkt_cnt` and `idle_cnt` = 0;
  - `empty` = 1, `full` = 0, `valid_out` = 0.
  - Memory contents are not reset.
- Reset is asynchronous: asserting `resetn` mid-packet clears everything immediately, regardless of the clock. Operation resumes on the first rising edge after deassertion.
- Write-to-valid latency: a write at edge N makes `valid_out` = 1 after edge N.
- Read latency: `read_enb` high at edge N (with `valid_out` = 1) updates `data_out` after edge N. The destination samples `data_out` at edge N+1.
- `valid_out` falls after the edge that reads the last entry.
- Back-to-back reads: holding `read_enb` high streams one byte per cycle.
- Flag timing: `full` asserts after the 16th unread write; `empty` reasserts after the read that drains the FIFO.
- Soft-reset timing: with data present and `read_enb` held low from edge 1 onward, the flush happens at edge 30 and `soft_reset` is high from edge 30 to edge 31.

## Test plan
- Reset check: assert `resetn` = 0 → `data_out` = 0x00, `valid_out` = 0, `empty` = 1, `full` = 0, `soft_reset` = 0.
- Single packet:
  - Stimulus: write header 0x0C with `lfd_state` = 1, then 0x11, 0x22, 0x33 and parity 0x00.
  - Response: `valid_out` = 1 the next cycle.
  - Hold `read_enb` = 1 for 5 cycles → `data_out` sequence 0x0C, 0x11, 0x22, 0x33, 0x00; `valid_out` = 0 after the 5th read.
- Full boundary:
  - 16 writes → `full` = 1.
  - A 17th write is ignored: reading back yields exactly the 16 bytes in order.
  - Pointers wrap correctly on a second fill.
- Simultaneous read and write:
  - At 1 entry, read and write together → the entry count stays 1 and `data_out` = the oldest byte.
  - When full, read and write together → count drops to 15 and the write is dropped.
- Timeout:
  - Write 3 bytes and keep `read_enb` = 0 → at the 30th cycle `soft_reset` pulses for 1 cycle, then `empty` = 1 and `data_out` = 0.
  - Asserting `read_enb` at cycle 29 instead → no soft reset.
- Mid-operation reset: drop `resetn` asynchronously during a streaming read → all outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/router_modport_if.sv
// Handshake bundle between the router core, a destination agent and one
// destination output port of the 1x3 router.
interface router_modport_if #(
    parameter int WIDTH = 8
);
    logic             write_enb;
    logic             lfd_state;
    logic [WIDTH-1:0] data_in;
    logic             read_enb;
    logic [WIDTH-1:0] data_out;
    logic             valid_out;
    logic             full;
    logic             empty;
    logic             soft_reset;

    // Core and destination agent together drive the port.
    modport master (
        output write_enb, lfd_state, data_in, read_enb,
        input  data_out, valid_out, full, empty, soft_reset
    );

    // The output port itself.
    modport slave (
        input  write_enb, lfd_state, data_in, read_enb,
        output data_out, valid_out, full, empty, soft_reset
    );
endinterface

// File: rtl/router_modport.sv
// Destination output port of the 1x3 router: FIFO of {header flag, byte}
// with read handshake and a self-flush when the destination stops reading.
module router_modport #(
    parameter int DEPTH   = 16,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 30
) (
    input logic             clock,
    input logic             resetn,
    router_modport_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int IW = $clog2(TIMEOUT);

    logic [WIDTH:0]   mem [DEPTH];

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic [5:0]       pkt_cnt_q, pkt_cnt_d;
    logic [IW-1:0]    idle_cnt_q, idle_cnt_d;
    logic             soft_reset_q;

    logic             empty, full;
    logic             do_wr, do_rd;
    logic             idle_cond, flush;
    logic [WIDTH:0]   rd_word;

    // Extra pointer MSB distinguishes full from empty when the low bits match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);

    assign idle_cond = !empty && !bus.read_enb;
    assign flush     = idle_cond && (idle_cnt_q == IW'(TIMEOUT - 1));
    assign do_wr     = bus.write_enb && !full && !flush;
    assign do_rd     = bus.read_enb && !empty;
    assign rd_word   = mem[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        data_out_d = data_out_q;
        pkt_cnt_d  = pkt_cnt_q;
        idle_cnt_d = idle_cnt_q;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            data_out_d = '0;
            pkt_cnt_d  = '0;
            idle_cnt_d = '0;
        end else begin
            if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_rd) begin
                rd_ptr_d   = rd_ptr_q + 1'b1;
                data_out_d = rd_word[WIDTH-1:0];
                // Header carries payload length in its upper six bits; +1 for parity.
                if (rd_word[WIDTH])
                    pkt_cnt_d = rd_word[WIDTH-1:WIDTH-6] + 6'd1;
                else if (pkt_cnt_q != 6'd0)
                    pkt_cnt_d = pkt_cnt_q - 6'd1;
            end
            idle_cnt_d = idle_cond ? idle_cnt_q + IW'(1) : '0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            data_out_q   <= '0;
            pkt_cnt_q    <= '0;
            idle_cnt_q   <= '0;
            soft_reset_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            data_out_q   <= data_out_d;
            pkt_cnt_q    <= pkt_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            soft_reset_q <= flush;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clock) begin
        if (do_wr) mem[wr_ptr_q[AW-1:0]] <= {bus.lfd_state, bus.data_in};
    end

    assign bus.data_out   = data_out_q;
    assign bus.valid_out  = !empty;
    assign bus.full       = full;
    assign bus.empty      = empty;
    assign bus.soft_reset = soft_reset_q;
endmodule

// File: tb/tb_router_modport.sv
// Directed bench for router_modport with a byte scoreboard queue.
module tb_router_modport;
    localparam int DEPTH = 16;
    localparam int WIDTH = 8;

    logic clock;
    logic resetn;
    int   vec     = 0;
    int   miscmp  = 0;
    logic [WIDTH-1:0] sb [$];

    router_modport_if #(.WIDTH(WIDTH)) bus ();

    router_modport #(.DEPTH(DEPTH), .WIDTH(WIDTH), .TIMEOUT(30)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            miscmp++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock with a scoreboard update; inputs idle again afterwards.
    task automatic tick(input logic wr, input logic lfd, input logic [WIDTH-1:0] d, input logic rd);
        logic             exp_rd;
        logic             exp_wr;
        logic [WIDTH-1:0] popped;
        bus.write_enb = wr;
        bus.lfd_state = lfd;
        bus.data_in   = d;
        bus.read_enb  = rd;
        exp_rd = rd && (sb.size() > 0);
        exp_wr = wr && (sb.size() < DEPTH);
        popped = '0;
        if (exp_rd) popped = sb.pop_front();
        if (exp_wr) sb.push_back(d);
        @(posedge clock);
        #1;
        if (exp_rd) chk("data_out", bus.data_out, popped);
        chk("valid_out", bus.valid_out, sb.size() != 0);
        chk("full", bus.full, sb.size() == DEPTH);
        chk("empty", bus.empty, sb.size() == 0);
        chk("soft_reset_quiet", bus.soft_reset, 1'b0);
        bus.write_enb = 1'b0;
        bus.lfd_state = 1'b0;
        bus.read_enb  = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_data_out"}, bus.data_out, 8'h00);
        chk({tag, "_valid_out"}, bus.valid_out, 1'b0);
        chk({tag, "_empty"}, bus.empty, 1'b1);
        chk({tag, "_full"}, bus.full, 1'b0);
        chk({tag, "_soft_reset"}, bus.soft_reset, 1'b0);
    endtask

    initial begin
        logic [WIDTH-1:0] pkt [5];
        pkt[0] = 8'h0C; pkt[1] = 8'h11; pkt[2] = 8'h22; pkt[3] = 8'h33; pkt[4] = 8'h00;

        resetn        = 1'b0;
        bus.write_enb = 1'b0;
        bus.lfd_state = 1'b0;
        bus.data_in   = '0;
        bus.read_enb  = 1'b0;
        #23;
        chk_reset_outputs("reset");
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock);
        #1;

        // Single packet: header then payload and parity, streamed out.
        for (int i = 0; i < 5; i++) tick(1'b1, i == 0, pkt[i], 1'b0);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, '0, 1'b1);
        chk("pkt_drained_valid", bus.valid_out, 1'b0);

        // Full boundary with a rejected 17th write, done twice to wrap pointers.
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < DEPTH; i++) tick(1'b1, 1'b0, 8'(i * 7 + 3 + pass * 64), 1'b0);
            chk("fill_full", bus.full, 1'b1);
            tick(1'b1, 1'b0, 8'hFF, 1'b0);
            for (int i = 0; i < DEPTH; i++) tick(1'b0, 1'b0, '0, 1'b1);
            chk("fill_drained_empty", bus.empty, 1'b1);
        end

        // Simultaneous read and write at one entry, then at full.
        tick(1'b1, 1'b0, 8'hA1, 1'b0);
        tick(1'b1, 1'b0, 8'hA2, 1'b1);
        chk("rw_one_oldest", bus.data_out, 8'hA1);
        tick(1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < DEPTH; i++) tick(1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
        vec++;
        assert (sb.size() == DEPTH) else begin
            miscmp++;
            $error("FAIL rw_fill_model: observed %0d expected %0d", sb.size(), DEPTH);
        end
        bus.write_enb = 1'b1; bus.data_in = 8'hEE; bus.read_enb = 1'b1;
        void'(sb.pop_front());
        @(posedge clock);
        #1;
        bus.write_enb = 1'b0; bus.read_enb = 1'b0;
        chk("rw_full_data", bus.data_out, 8'h40);
        chk("rw_full_not_full", bus.full, 1'b0);
        for (int i = 0; i < DEPTH - 1; i++) tick(1'b0, 1'b0, '0, 1'b1);
        chk("rw_full_drop_empty", bus.empty, 1'b1);

        // Timeout: three bytes left unread flush at the 30th idle edge.
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 8'(8'h70 + i), 1'b0);
        for (int i = 0; i < 27; i++) tick(1'b0, 1'b0, '0, 1'b0);
        bus.write_enb = 1'b1; bus.data_in = 8'h99;
        @(posedge clock);
        #1;
        bus.write_enb = 1'b0;
        sb.delete();
        chk("flush_pulse", bus.soft_reset, 1'b1);
        chk("flush_empty", bus.empty, 1'b1);
        chk("flush_data_out", bus.data_out, 8'h00);
        @(posedge clock);
        #1;
        chk("flush_pulse_end", bus.soft_reset, 1'b0);
        chk("flush_write_discarded", bus.empty, 1'b1);

        // Reading on the 29th idle cycle avoids the flush.
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 8'(8'h80 + i), 1'b0);
        for (int i = 0; i < 26; i++) tick(1'b0, 1'b0, '0, 1'b0);
        tick(1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, '0, 1'b0);
        tick(1'b0, 1'b0, '0, 1'b1);
        tick(1'b0, 1'b0, '0, 1'b1);

        // Asynchronous reset in the middle of a streaming read.
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 8'(8'hC0 + i), 1'b0);
        tick(1'b0, 1'b0, '0, 1'b1);
        bus.read_enb = 1'b1;
        #2;
        resetn = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        bus.read_enb = 1'b0;
        sb.delete();
        @(negedge clock);
        resetn = 1'b1;
        tick(1'b1, 1'b0, 8'h5A, 1'b0);
        tick(1'b0, 1'b0, '0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
        $finish;
    end
endmodule
